matrix_writeback: RTL and testbench
===================================

MATRIX_WRITEBACK -- requirements
Module: matrix_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter MEM_DEPTH, default 8, rows per bank.
REQ-003 Parameter IN_LANE_NUM, default 3, skewed lanes arriving from the compute array.
REQ-004 Parameter OUT_BANK_NUM, default 8, memory banks written in parallel; SHALL be >= IN_LANE_NUM.
REQ-005 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), bank address width.
REQ-006 clk  input  1  single clock, all logic on its rising edge.
REQ-007 nrst  input  1  reset, asynchronous, active-low.
REQ-008 en_wb  input  1  start pulse, sampled in IDLE only.
REQ-009 data_valid_i  input  1  qualifies lane_i this cycle.
REQ-010 lane_i  input  [IN_LANE_NUM][DATA_WIDTH]  skewed lane data.
REQ-011 addr_row_o  output  [OUT_BANK_NUM][ADDR_WIDTH]  per-bank write address.
REQ-012 wr_en_o  output  [OUT_BANK_NUM]  per-bank write strobe.
REQ-013 mem_row_o  output  [OUT_BANK_NUM][DATA_WIDTH]  per-bank write data.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse after the last row is written.

Function
REQ-016 States: IDLE, COLLECT, WRITE; IDLE->COLLECT on en_wb; COLLECT->WRITE when the last pass ends; WRITE->IDLE after MEM_DEPTH write cycles.
REQ-017 Constants: LATENCY = MEM_DEPTH+IN_LANE_NUM-1; PASSES = OUT_BANK_NUM-IN_LANE_NUM+1.
REQ-018 Entering COLLECT clears the buffer (OUT_BANK_NUM x MEM_DEPTH elements), row_cnt and col_cnt to 0.
REQ-019 row_cnt advances only on cycles with data_valid_i=1; cycles with data_valid_i=0 are stalls and change nothing.
REQ-020 On a valid cycle, lane u is accepted only when u <= row_cnt <= MEM_DEPTH-1+u; it targets bank col_cnt+u, row row_cnt-u.
REQ-021 Lane data outside its window is ignored, whatever its value.
REQ-022 Accepted data is added into the target element, modulo 2^DATA_WIDTH, with no saturation.
REQ-023 A valid cycle with row_cnt = LATENCY-1 ends the pass: row_cnt returns to 0 and col_cnt increments.
REQ-024 The end of pass PASSES-1 moves the block to WRITE on the next edge.
REQ-025 WRITE lasts exactly MEM_DEPTH cycles.
REQ-026 In WRITE cycle k, every bank has wr_en_o=1, addr_row_o=k and mem_row_o equal to buffer[bank][k].
REQ-027 done_o pulses in the first IDLE cycle after WRITE.
REQ-028 Outside WRITE, wr_en_o, addr_row_o and mem_row_o are 0.
REQ-029 en_wb outside IDLE is ignored; data_valid_i in IDLE or WRITE is ignored.
REQ-030 en_wb in the same cycle as done_o starts a new job (IDLE->COLLECT).

Reset
REQ-031 nrst low asynchronously forces IDLE and clears the counters, buffer, busy_o, done_o, wr_en_o, addr_row_o and mem_row_o to 0, including mid-COLLECT or mid-WRITE.
REQ-032 After reset no partial write completes and done_o is not pulsed.

Structure
REQ-033 Package matrix_wb_pkg holds the state enum and the LATENCY/PASSES constant functions.
REQ-034 One sub-module, matrix_writeback_bank, holds one bank column: MEM_DEPTH accumulators, accept/add port, read port and clear.
REQ-035 Top instantiates OUT_BANK_NUM banks via generate.

Verification
Defaults throughout: DATA_WIDTH=8, MEM_DEPTH=8, IN_LANE_NUM=3, OUT_BANK_NUM=8; hence PASSES=6, LATENCY=10.
REQ-036 Single-source: only lane 0 nonzero (=1) in its window, all passes -> banks 0..5 rows 0..7 =1, banks 6..7 =0, 8 write cycles, then done_o.
REQ-037 Full overlap: all lanes =1 in-window on every pass -> bank0=1, bank1=2, banks2..5=3, bank6=2, bank7=1, all rows.
REQ-038 Stalls: insert data_valid_i=0 every third cycle into the scenario REQ-037 stream -> identical results; WRITE entered only after 60 valid cycles.
REQ-039 Out-of-window garbage: lane2=0xFF at row_cnt 0..1 -> ignored, results unchanged.
REQ-040 Wrap: lane values 0x80 on two overlapping lanes -> affected elements = 0x00.
REQ-041 Reset in WRITE cycle 3 -> outputs 0 immediately, no done_o, and the next job runs clean.

Source files
------------

// File: rtl/matrix_wb_pkg.sv
// Shared types and sizing helpers for the matrix writeback block.
package matrix_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } wb_state_e;

  function automatic int unsigned calc_latency(input int unsigned mem_depth,
                                               input int unsigned lane_num);
    return mem_depth + lane_num - 1;
  endfunction

  function automatic int unsigned calc_passes(input int unsigned bank_num,
                                              input int unsigned lane_num);
    return bank_num - lane_num + 1;
  endfunction

endpackage

// File: rtl/matrix_writeback_if.sv
// Lane input and bank write bus of the matrix writeback block.
interface matrix_writeback_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH    = 8,
  parameter int unsigned IN_LANE_NUM  = 3,
  parameter int unsigned OUT_BANK_NUM = 8,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH)
);
  logic                                   en_wb;
  logic                                   data_valid_i;
  logic [IN_LANE_NUM-1:0][DATA_WIDTH-1:0] lane_i;
  logic [OUT_BANK_NUM-1:0][ADDR_WIDTH-1:0] addr_row_o;
  logic [OUT_BANK_NUM-1:0]                wr_en_o;
  logic [OUT_BANK_NUM-1:0][DATA_WIDTH-1:0] mem_row_o;
  logic                                   busy_o;
  logic                                   done_o;

  modport master (
    output en_wb, data_valid_i, lane_i,
    input  addr_row_o, wr_en_o, mem_row_o, busy_o, done_o
  );

  modport slave (
    input  en_wb, data_valid_i, lane_i,
    output addr_row_o, wr_en_o, mem_row_o, busy_o, done_o
  );
endinterface

// File: rtl/matrix_writeback_bank.sv
// One bank column: MEM_DEPTH wrapping accumulators with clear and a read port.
module matrix_writeback_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr_i,
  input  logic                  acc_en_i,
  input  logic [ADDR_WIDTH-1:0] acc_row_i,
  input  logic [DATA_WIDTH-1:0] acc_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_row_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  logic [DATA_WIDTH-1:0] acc_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] acc_d;

  assign acc_d     = acc_q[acc_row_i] + acc_data_i;
  assign rd_data_o = acc_q[rd_row_i];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) acc_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) acc_q[i] <= '0;
    end else if (acc_en_i) begin
      acc_q[acc_row_i] <= acc_d;
    end
  end
endmodule

// File: rtl/matrix_writeback.sv
// De-skews systolic lane output into per-bank accumulators, then writes all banks row by row.
module matrix_writeback
  import matrix_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH    = 8,
  parameter int unsigned IN_LANE_NUM  = 3,
  parameter int unsigned OUT_BANK_NUM = 8,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               nrst,
  matrix_writeback_if.slave  bus
);
  localparam int unsigned LATENCY = calc_latency(MEM_DEPTH, IN_LANE_NUM);
  localparam int unsigned PASSES  = calc_passes(OUT_BANK_NUM, IN_LANE_NUM);
  localparam int unsigned ROW_W   = $clog2(LATENCY + 1);
  localparam int unsigned COL_W   = $clog2(PASSES + 1);

  wb_state_e             state_q;
  logic [ROW_W-1:0]      row_cnt_q;
  logic [COL_W-1:0]      col_cnt_q;
  logic [ADDR_WIDTH-1:0] wr_row_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic                  done_q;

  logic clr, collect_valid, last_row, last_pass;
  logic [OUT_BANK_NUM-1:0]                 acc_en;
  logic [OUT_BANK_NUM-1:0][ADDR_WIDTH-1:0] acc_row;
  logic [OUT_BANK_NUM-1:0][DATA_WIDTH-1:0] acc_data;
  logic [OUT_BANK_NUM-1:0][DATA_WIDTH-1:0] rd_data;
  logic [OUT_BANK_NUM-1:0][DATA_WIDTH-1:0] mem_row;
  logic [OUT_BANK_NUM-1:0][ADDR_WIDTH-1:0] addr_row;

  assign clr           = (state_q == ST_IDLE) && bus.en_wb;
  assign collect_valid = (state_q == ST_COLLECT) && bus.data_valid_i;
  assign last_row      = (row_cnt_q == ROW_W'(LATENCY - 1));
  assign last_pass     = (col_cnt_q == COL_W'(PASSES - 1));

  // Lane u lands on bank col+u; each bank sees at most one lane per cycle.
  always_comb begin
    acc_en   = '0;
    acc_row  = '0;
    acc_data = '0;
    for (int unsigned b = 0; b < OUT_BANK_NUM; b++) begin
      for (int unsigned u = 0; u < IN_LANE_NUM; u++) begin
        if (collect_valid && (b == 32'(col_cnt_q) + u) &&
            (32'(row_cnt_q) >= u) && (32'(row_cnt_q) <= MEM_DEPTH - 1 + u)) begin
          acc_en[b]   = 1'b1;
          acc_row[b]  = ADDR_WIDTH'(row_cnt_q - ROW_W'(u));
          acc_data[b] = bus.lane_i[u];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      wr_row_q  <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.en_wb) begin
            state_q   <= ST_COLLECT;
            busy_q    <= 1'b1;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
          end
        end
        ST_COLLECT: begin
          if (bus.data_valid_i) begin
            if (last_row) begin
              row_cnt_q <= '0;
              col_cnt_q <= col_cnt_q + 1'b1;
              if (last_pass) begin
                state_q  <= ST_WRITE;
                wr_en_q  <= 1'b1;
                wr_row_q <= '0;
              end
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wr_row_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
            state_q  <= ST_IDLE;
            wr_en_q  <= 1'b0;
            wr_row_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            wr_row_q <= wr_row_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < OUT_BANK_NUM; b++) begin : g_bank
    matrix_writeback_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk        (clk),
      .nrst       (nrst),
      .clr_i      (clr),
      .acc_en_i   (acc_en[b]),
      .acc_row_i  (acc_row[b]),
      .acc_data_i (acc_data[b]),
      .rd_row_i   (wr_row_q),
      .rd_data_o  (rd_data[b])
    );
  end

  always_comb begin
    mem_row  = '0;
    addr_row = '0;
    for (int unsigned b = 0; b < OUT_BANK_NUM; b++) begin
      mem_row[b]  = wr_en_q ? rd_data[b] : '0;
      addr_row[b] = wr_row_q;
    end
  end

  assign bus.mem_row_o  = mem_row;
  assign bus.addr_row_o = addr_row;
  assign bus.wr_en_o    = {OUT_BANK_NUM{wr_en_q}};
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_matrix_writeback.sv
// Scoreboard bench for matrix_writeback: expected bank rows are queued while lanes are driven.
module tb_matrix_writeback;
  localparam int unsigned DW  = 8;
  localparam int unsigned MD  = 8;
  localparam int unsigned NL  = 3;
  localparam int unsigned NB  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned LAT = 10;
  localparam int unsigned PAS = 6;

  typedef logic [NB-1:0][DW-1:0] row_t;
  typedef logic [NB-1:0][AW-1:0] addr_t;

  logic clk;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_idx   = 0;
  row_t sb_q[$];
  logic [DW-1:0] model [NB][MD];

  matrix_writeback_if #(
    .DATA_WIDTH(DW), .MEM_DEPTH(MD), .IN_LANE_NUM(NL), .OUT_BANK_NUM(NB), .ADDR_WIDTH(AW)
  ) bus ();

  matrix_writeback #(
    .DATA_WIDTH(DW), .MEM_DEPTH(MD), .IN_LANE_NUM(NL), .OUT_BANK_NUM(NB), .ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write-side monitor: full-strobe cycles pop the scoreboard, all others must be quiet.
  always @(negedge clk) begin
    row_t  exp_row;
    addr_t exp_addr;
    if (nrst) begin
      if (bus.wr_en_o == '1) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          exp_row = sb_q.pop_front();
          for (int b = 0; b < NB; b++) exp_addr[b] = AW'(wr_idx);
          check_eq("mem_row", bus.mem_row_o, exp_row);
          check_eq("addr_row", bus.addr_row_o, exp_addr);
        end
        wr_idx++;
      end else begin
        check_eq("wr_en_idle", bus.wr_en_o, 0);
        check_eq("mem_row_idle", bus.mem_row_o, 0);
        check_eq("addr_row_idle", bus.addr_row_o, 0);
      end
    end
  end

  function automatic logic [DW-1:0] lane_val(input int mode, input int u, input int r);
    bit inwin;
    inwin = (r >= u) && (r <= MD - 1 + u);
    if (!inwin) return (mode == 3 && u == 2) ? 8'hFF : DW'($urandom);
    case (mode)
      0:       return (u == 0) ? 8'd1 : 8'd0;
      4:       return (u < 2) ? 8'h80 : 8'h00;
      5:       return DW'($urandom);
      default: return 8'd1;
    endcase
  endfunction

  task automatic run_job(input int mode, input bit started, input bit abort);
    int cyc = 0;
    logic [DW-1:0] v;
    row_t e;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < MD; k++) model[b][k] = '0;
    wr_idx = 0;
    if (!started) begin
      @(negedge clk);
      bus.en_wb = 1'b1;
    end
    @(negedge clk);
    bus.en_wb = 1'b0;
    check_eq("busy_collect", bus.busy_o, 1);
    check_eq("done_low_collect", bus.done_o, 0);
    for (int p = 0; p < PAS; p++) begin
      for (int r = 0; r < LAT; r++) begin
        if (mode == 2 && (cyc % 3) == 2) begin
          bus.data_valid_i = 1'b0;
          bus.en_wb        = 1'b1;
          for (int u = 0; u < NL; u++) bus.lane_i[u] = DW'($urandom);
          @(negedge clk);
          cyc++;
          bus.en_wb = 1'b0;
        end
        for (int u = 0; u < NL; u++) begin
          v = lane_val(mode, u, r);
          bus.lane_i[u] = v;
          if (r >= u && r <= MD - 1 + u) model[p + u][r - u] = model[p + u][r - u] + v;
        end
        bus.data_valid_i = 1'b1;
        if (p == PAS - 1 && r == LAT - 1) begin
          for (int k = 0; k < MD; k++) begin
            for (int b = 0; b < NB; b++) e[b] = model[b][k];
            sb_q.push_back(e);
          end
        end
        @(negedge clk);
        cyc++;
        if (!(p == PAS - 1 && r == LAT - 1)) check_eq("no_early_write", bus.wr_en_o, 0);
      end
    end
    bus.data_valid_i = 1'b0;
    for (int u = 0; u < NL; u++) bus.lane_i[u] = DW'($urandom);
    check_eq("enter_write", bus.wr_en_o, {NB{1'b1}});
    if (abort) begin
      repeat (3) @(negedge clk);
      #1 nrst = 1'b0;
      #1;
      check_eq("rst_wr_en", bus.wr_en_o, 0);
      check_eq("rst_mem_row", bus.mem_row_o, 0);
      check_eq("rst_addr_row", bus.addr_row_o, 0);
      check_eq("rst_busy", bus.busy_o, 0);
      check_eq("rst_done", bus.done_o, 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      repeat (12) begin
        @(negedge clk);
        check_eq("no_done_after_rst", bus.done_o, 0);
      end
    end
  endtask

  task automatic wait_done(input bit chain);
    bit found = 1'b0;
    for (int i = 0; i < MD + 4 && !found; i++) begin
      @(negedge clk);
      if (bus.done_o) found = 1'b1;
    end
    check_eq("done_seen", found, 1);
    if (found) begin
      check_eq("wr_count", wr_idx, MD);
      check_eq("sb_empty", sb_q.size(), 0);
      check_eq("busy_done", bus.busy_o, 0);
      if (chain) begin
        bus.en_wb = 1'b1;
      end else begin
        @(negedge clk);
        check_eq("done_pulse", bus.done_o, 0);
      end
    end
  endtask

  initial begin
    nrst             = 1'b0;
    bus.en_wb        = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.lane_i       = '0;
    #3;
    check_eq("reset_busy", bus.busy_o, 0);
    check_eq("reset_done", bus.done_o, 0);
    check_eq("reset_wr_en", bus.wr_en_o, 0);
    check_eq("reset_mem_row", bus.mem_row_o, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    check_eq("valid_in_idle", bus.busy_o, 0);
    bus.data_valid_i = 1'b0;

    run_job(0, 1'b0, 1'b0); wait_done(1'b0);
    run_job(1, 1'b0, 1'b0); wait_done(1'b1);
    run_job(2, 1'b1, 1'b0); wait_done(1'b0);
    run_job(3, 1'b0, 1'b0); wait_done(1'b0);
    run_job(4, 1'b0, 1'b0); wait_done(1'b0);
    run_job(1, 1'b0, 1'b1);
    run_job(5, 1'b0, 1'b0); wait_done(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
